// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - IDCT_V2 shared constants, FSM state type and Q14 cosine table
package idct_pkg;

  localparam int N      = 8;
  localparam int COEF_W = 32;
  localparam int ACC_W  = 48;
  localparam int FRAC   = 14;
  localparam int COS_W  = 16;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} state_t;

  localparam logic signed [ACC_W-1:0] ROUND_HALF  = 48'sd8192;
  localparam logic signed [ACC_W-1:0] LEVEL_SHIFT = 48'sd128;
  localparam logic signed [ACC_W-1:0] SAT_LO      = 48'sd0;
  localparam logic signed [ACC_W-1:0] SAT_HI      = 48'sd255;

  // Indexed {k, n}: eight entries per frequency row k.
  localparam logic signed [COS_W-1:0] COS_TAB [0:63] = '{
    16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
    16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035,
    16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568,
    16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811,
    16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,
    16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551,
    16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135,
    16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598
  };

  function automatic logic [7:0] clamp_u8(input logic signed [ACC_W-1:0] v);
    if (v < SAT_LO)
      return 8'd0;
    else if (v > SAT_HI)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/idct_cos_rom.sv
// rtl/idct_cos_rom.sv - combinational Q14 cosine lookup C[k][n]
module idct_cos_rom
  import idct_pkg::*;
(
  input  logic [2:0]              k,
  input  logic [2:0]              n,
  output logic signed [COS_W-1:0] coef
);

  assign coef = COS_TAB[{k, n}];

endmodule

// File: rtl/idct_v2.sv
// rtl/idct_v2.sv - 8-point 1-D IDCT, serial load / MAC / emit; IDCT_LEVEL_SHIFT_EN adds +128 before clamp
module idct_v2
  import idct_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [COEF_W-1:0] data_in,
  output logic [7:0]               data_out,
  output logic                     exportSample,
  output logic                     finish,
  output logic                     busy
);

  state_t                    state;
  state_t                    state_nxt;
  logic [2:0]                k_cnt;
  logic [2:0]                n_cnt;
  logic signed [COEF_W-1:0]  coef_q [N];
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [COS_W-1:0]   cos_c;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   rounded;
  logic [7:0]                sample;

  idct_cos_rom u_rom (
    .k    (k_cnt),
    .n    (n_cnt),
    .coef (cos_c)
  );

  // The final sum is formed combinationally so data_out lands exactly as EMIT begins.
  always_comb begin
    term     = ACC_W'(coef_q[k_cnt]) * ACC_W'(cos_c);
    acc_base = (k_cnt == 3'd0) ? SAT_LO : acc_q;
    acc_sum  = acc_base + term;
    rounded  = (acc_sum + ROUND_HALF) >>> FRAC;
`ifdef IDCT_LEVEL_SHIFT_EN
    rounded  = rounded + LEVEL_SHIFT;
`endif
    sample   = clamp_u8(rounded);
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)          state_nxt = LOAD;
      LOAD: if (k_cnt == 3'd7)  state_nxt = MAC;
      MAC:  if (k_cnt == 3'd7)  state_nxt = EMIT;
      EMIT: state_nxt = (n_cnt == 3'd7) ? IDLE : MAC;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    exportSample = (state == EMIT);
    finish       = (state == EMIT) && (n_cnt == 3'd7);
  end

  // k_cnt and n_cnt wrap 7->0 naturally, leaving both at zero for the next phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_cnt    <= '0;
      n_cnt    <= '0;
      acc_q    <= '0;
      data_out <= '0;
      for (int i = 0; i < N; i++)
        coef_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            coef_q[0] <= data_in;
            k_cnt     <= 3'd1;
            n_cnt     <= 3'd0;
          end
        end
        LOAD: begin
          coef_q[k_cnt] <= data_in;
          k_cnt         <= k_cnt + 3'd1;
        end
        MAC: begin
          acc_q <= acc_sum;
          k_cnt <= k_cnt + 3'd1;
          if (k_cnt == 3'd7)
            data_out <= sample;
        end
        EMIT: begin
          n_cnt <= n_cnt + 3'd1;
        end
        default: begin
          k_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idct_v2.sv
// tb/tb_idct_v2.sv - self-checking bench for idct_v2 against a floating-point IDCT model
module tb_idct_v2;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [31:0] data_in;
  logic [7:0]         data_out;
  logic               exportSample;
  logic               finish;
  logic               busy;

  idct_v2 dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .data_in      (data_in),
    .data_out     (data_out),
    .exportSample (exportSample),
    .finish       (finish),
    .busy         (busy)
  );

  always #5 clk = ~clk;

`ifdef IDCT_LEVEL_SHIFT_EN
  localparam int LS = 128;
`else
  localparam int LS = 0;
`endif

  typedef struct {
    longint due;
    int     val;
    bit     last;
  } exp_t;

  exp_t   exp_q[$];
  longint cyc      = 0;
  longint busy_lo  = 1;
  longint busy_hi  = 0;
  int     last_out = 0;
  bit     armed    = 1'b0;
  bit     exp_ex;
  int     nerr     = 0;
  int     nchk     = 0;
  int     xv[8];
  int     e28[8];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cos_q14(int k, int n);
    real a;
    real v;
    a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
    v = 16384.0 * a * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int model_out(int n);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < 8; k++)
      acc += longint'(xv[k]) * longint'(cos_q14(k, n));
    r = ((acc + 64'sd8192) >>> 14) + longint'(LS);
    if (r < 0) return 0;
    if (r > 255) return 255;
    return int'(r);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      exp_ex = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("exportSample", 64'(exportSample), 64'(exp_ex));
      check("busy", 64'(busy), 64'((cyc >= busy_lo) && (cyc <= busy_hi)));
      if (exp_ex) begin
        check("data_out", 64'(data_out), 64'(exp_q[0].val));
        check("finish", 64'(finish), 64'(exp_q[0].last));
        last_out = exp_q[0].val;
        void'(exp_q.pop_front());
      end else begin
        check("data_out_hold", 64'(data_out), 64'(last_out));
        check("finish_quiet", 64'(finish), 64'd0);
      end
    end
    if (reset === 1'b1) begin
      armed    = 1'b1;
      exp_q.delete();
      busy_lo  = 1;
      busy_hi  = 0;
      last_out = 0;
    end
  end

  // Cycle 0 carries X[0]; hold keeps start high all block long; abort_at pulses reset.
  task automatic drive_block(input bit hold, input int abort_at);
    longint base;
    exp_t   e;
    @(posedge clk); #2;
    start   = 1'b1;
    data_in = xv[0];
    base    = cyc;
    for (int n = 0; n < 8; n++) begin
      e.due  = base + 16 + 9 * n;
      e.val  = model_out(n);
      e.last = (n == 7);
      exp_q.push_back(e);
    end
    busy_lo = base + 1;
    busy_hi = base + 79;
    for (int c = 1; c < 80; c++) begin
      @(posedge clk); #2;
      start   = hold;
      data_in = (c < 8) ? xv[c] : $urandom;
      if (c == abort_at) begin
        reset = 1'b1;
      end else if (c == abort_at + 1) begin
        reset = 1'b0;
        start = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #2;
      start   = 1'b0;
      data_in = $urandom;
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;

`ifdef IDCT_LEVEL_SHIFT_EN
    e28 = '{177, 170, 156, 138, 118, 100, 86, 79};
`else
    e28 = '{49, 42, 28, 10, 0, 0, 0, 0};
`endif

    xv = '{283, 0, 0, 0, 0, 0, 0, 0};
    for (int n = 0; n < 8; n++) check("pin_dc283", 64'(model_out(n)), 64'(100 + LS));
    xv = '{0, 100, 0, 0, 0, 0, 0, 0};
    for (int n = 0; n < 8; n++) check("pin_x1", 64'(model_out(n)), 64'(e28[n]));
    xv = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int n = 0; n < 8; n++) check("pin_zero", 64'(model_out(n)), 64'(LS));
    xv = '{10000, 0, 0, 0, 0, 0, 0, 0};
    for (int n = 0; n < 8; n++) check("pin_sat_hi", 64'(model_out(n)), 64'd255);
    xv = '{-1000, 0, 0, 0, 0, 0, 0, 0};
    for (int n = 0; n < 8; n++) check("pin_sat_lo", 64'(model_out(n)), 64'd0);

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    idle(2);

    xv = '{283, 0, 0, 0, 0, 0, 0, 0};              drive_block(1'b0, -5); idle(3);
    xv = '{0, 0, 0, 0, 0, 0, 0, 0};                drive_block(1'b0, -5); idle(1);
    xv = '{10000, 0, 0, 0, 0, 0, 0, 0};            drive_block(1'b0, -5); idle(2);
    xv = '{-1000, 0, 0, 0, 0, 0, 0, 0};            drive_block(1'b0, -5); idle(2);
    xv = '{0, 100, 0, 0, 0, 0, 0, 0};              drive_block(1'b0, -5); idle(2);
    xv = '{1200, -300, 250, -90, 40, -25, 10, -5}; drive_block(1'b0, -5); idle(2);

    xv = '{283, 0, 0, 0, 0, 0, 0, 0};              drive_block(1'b0, 30); idle(3);
    xv = '{-50, 37, 120, -8, 64, 3, -200, 15};     drive_block(1'b0, -5); idle(2);

    @(posedge clk); #2;
    reset   = 1'b1;
    start   = 1'b1;
    data_in = 32'sd283;
    @(posedge clk); #2;
    reset   = 1'b0;
    start   = 1'b0;
    idle(4);

    xv = '{283, 0, 0, 0, 0, 0, 0, 0};              drive_block(1'b1, -5);
    xv = '{0, 100, 0, 0, 0, 0, 0, 0};              drive_block(1'b1, -5);
    xv = '{1200, -300, 250, -90, 40, -25, 10, -5}; drive_block(1'b1, -5);
    idle(6);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/idct_v2.md
IDCT_V2 -- requirements
Module: idct_v2

Interface
REQ-001 SHALL: one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 SHALL: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL: reset  input  1  synchronous active-high reset.
REQ-004 SHALL: start  input  1  request; sampled only in IDLE, where it also qualifies X[0] on data_in.
REQ-005 SHALL: data_in  input  32  signed integer DCT coefficient X[k], k=0..7, one per cycle.
REQ-006 SHALL: data_out  output  8  unsigned reconstructed sample x[n], registered.
REQ-007 SHALL: exportSample  output  1  one-cycle pulse; data_out valid in that cycle.
REQ-008 SHALL: finish  output  1  one-cycle pulse coincident with the exportSample of x[7].
REQ-009 SHALL: busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL: compute the 8-point orthonormal 1-D inverse DCT, x[n] = sum_k a(k)*X[k]*cos((2n+1)k*pi/16), where a(0)=sqrt(1/8) and a(k>0)=1/2.
REQ-011 SHALL: states are IDLE, LOAD, MAC and EMIT.
REQ-012 SHALL: IDLE with start=1 captures data_in as X[0] and moves to LOAD; LOAD captures X[1..7] on the next 7 cycles unconditionally, regardless of start.
REQ-013 SHALL: MAC runs for each n=0..7 in ascending order, spending 8 cycles accumulating k=0..7, and is followed by one EMIT cycle.
REQ-014 SHALL: the cosine constants are C[k][n] = round(16384*a(k)*cos(...)), signed Q14 (C[0][n]=5793); the accumulator is 48-bit signed with no overflow possible.
REQ-015 SHALL: the result is clamp((acc + 8192) >>> 14, 0, 255), i.e. round-half-up followed by saturation.
REQ-016 SHALL: timing counts the X[0] capture as cycle 0; exportSample is high in cycles 16+9n for n=0..7; finish is high in cycle 79; the FSM is in IDLE at cycle 80.
REQ-017 SHALL: start while busy is ignored, and a new block may start in the first IDLE cycle after finish.
REQ-018 SHALL: data_out holds its last value when exportSample=0.

Reset
REQ-019 SHALL: reset forces IDLE and clears data_out=0, exportSample=0, finish=0, busy=0, the accumulator, the counters and the coefficient registers.
REQ-020 SHALL: reset asserted mid-block aborts the block with no further exportSample or finish, and reset dominates a simultaneous start.

Configuration
REQ-021 SHALL: macro IDCT_LEVEL_SHIFT_EN, when defined, adds +128 to the rounded result before clamping, giving JPEG level-shift semantics.
REQ-022 SHALL: without IDCT_LEVEL_SHIFT_EN, no offset is applied; timing is identical in both builds.

Structure
REQ-023 SHALL: package idct_pkg holds the 64-entry Q14 cosine table, the constants N=8, COEF_W=32, ACC_W=48, FRAC=14, and the state enum.
REQ-024 SHALL: sub-module idct_cos_rom is a combinational lookup of C[k][n] indexed by 3-bit k and 3-bit n.

Verification
REQ-025 SHALL: X={283,0,0,0,0,0,0,0} -> eight exportSample pulses, each data_out=100; finish at cycle 79.
REQ-026 SHALL: all X=0 -> data_out=0 x8; with IDCT_LEVEL_SHIFT_EN -> data_out=128 x8.
REQ-027 SHALL: X[0]=10000, rest 0 -> data_out=255 x8 (saturate high); X[0]=-1000 -> data_out=0 x8 (saturate low).
REQ-028 SHALL: X={0,100,0,0,0,0,0,0} -> data_out = 49,42,28,10,0,0,0,0 (cos-weighted, negative values clamped), matching a double-precision model rounded per REQ-015.
REQ-029 SHALL: reset pulsed at cycle 30 -> no further exportSample; busy=0 next cycle; a following block produces correct results.
REQ-030 SHALL: start held high for 200 cycles with continuous data -> back-to-back blocks, with the second X[0] captured at cycle 80.
